tx_symbol_scheduler: RTL

Per-lane transmit symbol scheduler that sits directly in front of `encoder_8b10b`. It sequences what the encoder sees every symbol time: logical idle, STP/END-framed packet bytes from the upstream link layer, and periodic SKP ordered sets. It produces one byte plus a K-character flag per enabled clock, ready for 8b/10b encoding.

---
 rtl/tx_symbol_scheduler.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/tx_symbol_scheduler.sv
// Transmit symbol scheduler in front of the 8b/10b encoder: idle, STP/END-framed packets, periodic SKP sets.
// Latency: one registered symbol per enabled clock; first packet byte is emitted one edge after STP.
// Backpressure: data_ready_o only in DATA while enabled. SKP insertion needs macro TX_SCHED_SKP_EN.
module tx_symbol_scheduler #(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_LEN      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_i,
  input  logic [7:0] data_i,
  input  logic       data_valid_i,
  input  logic       data_last_i,
  output logic       data_ready_o,
  output logic [7:0] data_o,
  output logic       k_o,
  output logic       skp_active_o,
  output logic       underrun_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_END  = 2'd2;
  localparam logic [1:0] ST_SKP  = 2'd3;

  localparam logic [7:0] SYM_COM  = 8'hBC;
  localparam logic [7:0] SYM_SKP  = 8'h1C;
  localparam logic [7:0] SYM_STP  = 8'hFB;
  localparam logic [7:0] SYM_END  = 8'hFD;
  localparam logic [7:0] SYM_PAD  = 8'hF7;
  localparam logic [7:0] SYM_IDLE = 8'h00;

  logic [1:0] r_state;
  logic [7:0] r_data;
  logic       r_k;
  logic       r_skp;
  logic       r_und;

  logic [1:0] w_state_nxt;
  logic [7:0] w_data_nxt;
  logic       w_k_nxt;
  logic       w_skp_nxt;
  logic       w_und_nxt;
  logic       w_skp_due;

`ifdef TX_SCHED_SKP_EN
  localparam int               CNT_W    = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SKP_INTERVAL - 1);
  localparam logic [2:0]       SKP_LAST = 3'(SKP_LEN - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_skp_idx;
  logic             w_com;

  assign w_skp_due = (r_cnt == CNT_MAX);
  // COM is launched only from IDLE, so a due set waits out any packet in flight.
  assign w_com     = enable_i && (r_state == ST_IDLE) && w_skp_due;

  // Interval counter: saturates while a SKP set is pending, restarts on the COM edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (enable_i) begin
      if (w_com) begin
        r_cnt <= '0;
      end else if (!w_skp_due) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Position within the ordered set: counts SKP symbols emitted after COM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_skp_idx <= '0;
    end else if (enable_i) begin
      if (w_com) begin
        r_skp_idx <= '0;
      end else if (r_state == ST_SKP) begin
        r_skp_idx <= r_skp_idx + 1'b1;
      end
    end
  end
`else
  logic w_unused_cfg;

  assign w_skp_due    = 1'b0;
  assign w_unused_cfg = (SKP_INTERVAL != 0) ^ (SKP_LEN != 0);
`endif

  // Next symbol and state selection for an enabled edge.
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_k_nxt     = r_k;
    w_skp_nxt   = r_skp;
    w_und_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_skp_due) begin
          w_data_nxt  = SYM_COM;
          w_k_nxt     = 1'b1;
          w_skp_nxt   = 1'b1;
          w_state_nxt = ST_SKP;
        end else if (data_valid_i) begin
          w_data_nxt  = SYM_STP;
          w_k_nxt     = 1'b1;
          w_skp_nxt   = 1'b0;
          w_state_nxt = ST_DATA;
        end else begin
          w_data_nxt  = SYM_IDLE;
          w_k_nxt     = 1'b0;
          w_skp_nxt   = 1'b0;
        end
      end
      ST_DATA: begin
        w_skp_nxt = 1'b0;
        if (data_valid_i) begin
          w_data_nxt = data_i;
          w_k_nxt    = 1'b0;
          if (data_last_i) begin
            w_state_nxt = ST_END;
          end
        end else begin
          // Upstream starved mid-packet: fill the slot with PAD and flag it.
          w_data_nxt = SYM_PAD;
          w_k_nxt    = 1'b1;
          w_und_nxt  = 1'b1;
        end
      end
      ST_END: begin
        w_data_nxt  = SYM_END;
        w_k_nxt     = 1'b1;
        w_skp_nxt   = 1'b0;
        w_state_nxt = ST_IDLE;
      end
`ifdef TX_SCHED_SKP_EN
      ST_SKP: begin
        w_data_nxt = SYM_SKP;
        w_k_nxt    = 1'b1;
        w_skp_nxt  = 1'b1;
        if (r_skp_idx == SKP_LAST) begin
          w_state_nxt = ST_IDLE;
        end
      end
`endif
      default: begin
        w_data_nxt  = SYM_IDLE;
        w_k_nxt     = 1'b0;
        w_skp_nxt   = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers: advance only on enabled edges; underrun is a pulse, never held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_data  <= SYM_IDLE;
      r_k     <= 1'b0;
      r_skp   <= 1'b0;
      r_und   <= 1'b0;
    end else if (enable_i) begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_k     <= w_k_nxt;
      r_skp   <= w_skp_nxt;
      r_und   <= w_und_nxt;
    end else begin
      r_und   <= 1'b0;
    end
  end

  assign data_ready_o = (r_state == ST_DATA) && enable_i;
  assign data_o       = r_data;
  assign k_o          = r_k;
  assign skp_active_o = r_skp;
  assign underrun_o   = r_und && enable_i;

endmodule
